// File: rtl/clkdiv_frac.sv
// Fractional clock divider: hclkin / (cfg_int + cfg_frac/2^FRAC_W).
// A first-order accumulator picks each period length (floor(D) or floor(D)+1),
// so the long-run average ratio is exact. Outputs a registered near-50% clkout,
// a single-cycle tick on the first cycle of each period, and a one-cycle
// phase-slip facility driven by calib.
module clkdiv_frac #(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned DEF_INT  = 3,
    parameter int unsigned DEF_FRAC = 8
) (
    input  logic              hclkin,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              cfg_err,
    input  logic              calib,
    output logic              clkout,
    output logic              tick,
    output logic [DIV_W-1:0]  active_int,
    output logic [FRAC_W-1:0] active_frac
);

    // One extra bit: active_int plus the accumulator carry can reach 2^DIV_W.
    localparam int unsigned CW = DIV_W + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       len;
    logic [CW-1:0]       high;
    logic [FRAC_W-1:0]   acc;
    logic                pending;
    logic [DIV_W-1:0]    pend_int;
    logic [FRAC_W-1:0]   pend_frac;
    logic                slip_req;
    logic                slipped;

    logic                cfg_fire;
    logic                cfg_bad;
    logic [DIV_W-1:0]    sel_int;
    logic [FRAC_W-1:0]   sel_frac;
    logic [FRAC_W-1:0]   base_acc;
    logic [FRAC_W:0]     sum;
    logic [CW-1:0]       nxt_len;
    logic [CW-1:0]       nxt_high;
    logic                at_end;
    logic                do_start;

    assign cfg_ready = ~pending;

    // Next-period arithmetic; a pending divisor takes effect with a fresh accumulator.
    always_comb begin
        cfg_fire = cfg_valid && !pending;
        cfg_bad  = (cfg_int < DIV_W'(2));
        sel_int  = pending ? pend_int  : active_int;
        sel_frac = pending ? pend_frac : active_frac;
        base_acc = pending ? '0 : acc;
        sum      = {1'b0, base_acc} + {1'b0, sel_frac};
        nxt_len  = {1'b0, sel_int} + CW'(sum[FRAC_W]);
        nxt_high = nxt_len - (nxt_len >> 1);
        at_end   = (cnt == len - CW'(1));
        do_start = enable && ((state == ST_IDLE) ||
                              (at_end && !(slip_req && !slipped)));
    end

    // Divider state machine, config handshake and registered outputs.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            len         <= '0;
            high        <= '0;
            acc         <= '0;
            pending     <= 1'b0;
            pend_int    <= '0;
            pend_frac   <= '0;
            slip_req    <= 1'b0;
            slipped     <= 1'b0;
            clkout      <= 1'b0;
            tick        <= 1'b0;
            cfg_err     <= 1'b0;
            active_int  <= DIV_W'(DEF_INT);
            active_frac <= FRAC_W'(DEF_FRAC);
        end else begin
            cfg_err <= cfg_fire && cfg_bad;
            if (cfg_fire && !cfg_bad) begin
                pending   <= 1'b1;
                pend_int  <= cfg_int;
                pend_frac <= cfg_frac;
            end

            if (do_start) begin
                if (pending) begin
                    active_int  <= pend_int;
                    active_frac <= pend_frac;
                    pending     <= 1'b0;
                end
                state    <= ST_RUN;
                acc      <= sum[FRAC_W-1:0];
                len      <= nxt_len;
                high     <= nxt_high;
                cnt      <= '0;
                clkout   <= 1'b1;
                tick     <= 1'b1;
                slipped  <= 1'b0;
                slip_req <= slip_req | ((state == ST_RUN) & calib);
            end else if (!enable || state == ST_IDLE) begin
                // Idle or just disabled: park outputs, flush pending config.
                if (pending) begin
                    active_int  <= pend_int;
                    active_frac <= pend_frac;
                    pending     <= 1'b0;
                end
                state    <= ST_IDLE;
                cnt      <= '0;
                acc      <= '0;
                clkout   <= 1'b0;
                tick     <= 1'b0;
                slip_req <= 1'b0;
                slipped  <= 1'b0;
            end else if (at_end) begin
                // Slip: hold the last (low) count one extra cycle.
                clkout   <= 1'b0;
                tick     <= 1'b0;
                slip_req <= 1'b0;
                slipped  <= 1'b1;
            end else begin
                cnt      <= cnt + CW'(1);
                tick     <= 1'b0;
                clkout   <= ((cnt + CW'(1)) < high);
                slip_req <= slip_req | calib;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_frac.sv
// Directed bench for clkdiv_frac with hand-computed tick/clkout patterns.
// Patterns are collected one bit per cycle, oldest bit in the MSB.
module tb_clkdiv_frac;

    logic       hclkin;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_int;
    logic [3:0] cfg_frac;
    logic       cfg_err;
    logic       calib;
    logic       clkout;
    logic       tick;
    logic [7:0] active_int;
    logic [3:0] active_frac;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] tk;
    logic [63:0] ck;

    clkdiv_frac #(
        .DIV_W   (8),
        .FRAC_W  (4),
        .DEF_INT (3),
        .DEF_FRAC(8)
    ) dut (
        .hclkin     (hclkin),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_int    (cfg_int),
        .cfg_frac   (cfg_frac),
        .cfg_err    (cfg_err),
        .calib      (calib),
        .clkout     (clkout),
        .tick       (tick),
        .active_int (active_int),
        .active_frac(active_frac)
    );

    initial begin
        hclkin = 1'b0;
        forever #5 hclkin = ~hclkin;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclkin);
        #1;
    endtask

    task automatic collect(input int n, output logic [63:0] t, output logic [63:0] c);
        t = '0;
        c = '0;
        for (int i = 0; i < n; i++) begin
            step();
            t = {t[62:0], tick};
            c = {c[62:0], clkout};
        end
    endtask

    task automatic wait_tick(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (tick) begin
                found = 1'b1;
                break;
            end
        end
        check_eq(tag, 64'(found), 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_frac  = '0;
        calib     = 1'b0;
        step();
        step();

        // Reset values
        check_eq("rst_clkout", 64'(clkout), 64'd0);
        check_eq("rst_tick", 64'(tick), 64'd0);
        check_eq("rst_ready", 64'(cfg_ready), 64'd1);
        check_eq("rst_err", 64'(cfg_err), 64'd0);
        check_eq("rst_int", 64'(active_int), 64'd3);
        check_eq("rst_frac", 64'(active_frac), 64'd8);

        // Default 3.5: periods 3,4,3,4
        reset  = 1'b0;
        enable = 1'b1;
        collect(14, tk, ck);
        check_eq("d35_tick", tk, 64'b10010001001000);
        check_eq("d35_clk", ck, 64'b11011001101100);

        // Update to 5.0 mid-period
        wait_tick("t2_align", 10);
        cfg_valid = 1'b1;
        cfg_int   = 8'd5;
        cfg_frac  = 4'd0;
        step();
        cfg_valid = 1'b0;
        check_eq("d5_ready_lo_a", 64'(cfg_ready), 64'd0);
        check_eq("d5_int_old", 64'(active_int), 64'd3);
        step();
        check_eq("d5_ready_lo_b", 64'(cfg_ready), 64'd0);
        step();
        check_eq("d5_start_tick", 64'(tick), 64'd1);
        check_eq("d5_ready_hi", 64'(cfg_ready), 64'd1);
        check_eq("d5_int", 64'(active_int), 64'd5);
        collect(10, tk, ck);
        check_eq("d5_tick", tk, 64'b0000100001);
        check_eq("d5_clk", ck, 64'b1100111001);

        // Update to 2.25: periods 2,2,2,3
        cfg_valid = 1'b1;
        cfg_int   = 8'd2;
        cfg_frac  = 4'd4;
        step();
        cfg_valid = 1'b0;
        wait_tick("t3_align", 10);
        check_eq("d225_int", 64'(active_int), 64'd2);
        check_eq("d225_frac", 64'(active_frac), 64'd4);
        collect(20, tk, ck);
        check_eq("d225_tick", tk, 64'b01010100101010100101);
        check_eq("d225_clk", ck, 64'b01010110101010110101);

        // Illegal cfg_int=1: dropped with error pulse
        cfg_valid = 1'b1;
        cfg_int   = 8'd1;
        cfg_frac  = 4'd0;
        step();
        cfg_valid = 1'b0;
        check_eq("bad_err_hi", 64'(cfg_err), 64'd1);
        check_eq("bad_ready", 64'(cfg_ready), 64'd1);
        check_eq("bad_tick_a", 64'(tick), 64'd0);
        step();
        check_eq("bad_err_lo", 64'(cfg_err), 64'd0);
        check_eq("bad_tick_b", 64'(tick), 64'd1);
        check_eq("bad_int", 64'(active_int), 64'd2);
        check_eq("bad_frac", 64'(active_frac), 64'd4);

        // Div 4.0, two calib pulses in one period -> one slip
        cfg_valid = 1'b1;
        cfg_int   = 8'd4;
        cfg_frac  = 4'd0;
        step();
        cfg_valid = 1'b0;
        wait_tick("t5_align", 10);
        check_eq("d4_int", 64'(active_int), 64'd4);
        calib = 1'b1;
        step();
        calib = 1'b0;
        step();
        calib = 1'b1;
        step();
        calib = 1'b0;
        collect(9, tk, ck);
        check_eq("slip_tick", tk, 64'b010001000);
        check_eq("slip_clk", ck, 64'b011001100);

        // Asynchronous reset in the high phase
        wait_tick("t6_align", 10);
        check_eq("pre_rst_clk", 64'(clkout), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_clk", 64'(clkout), 64'd0);
        check_eq("async_tick", 64'(tick), 64'd0);
        check_eq("async_int", 64'(active_int), 64'd3);
        check_eq("async_frac", 64'(active_frac), 64'd8);
        enable = 1'b0;
        #2;
        reset = 1'b0;
        step();
        check_eq("idle_clk", 64'(clkout), 64'd0);

        // Enable after reset: default pattern from the first edge
        enable = 1'b1;
        collect(7, tk, ck);
        check_eq("en_tick", tk, 64'b1001000);
        check_eq("en_clk", ck, 64'b1101100);
        step();
        check_eq("en_p3_tick", 64'(tick), 64'd1);

        // Drop enable mid-high, then re-enable: accumulator restarts
        enable = 1'b0;
        step();
        check_eq("dis_clk", 64'(clkout), 64'd0);
        check_eq("dis_tick", 64'(tick), 64'd0);
        step();
        check_eq("dis_clk_b", 64'(clkout), 64'd0);
        enable = 1'b1;
        collect(7, tk, ck);
        check_eq("reen_tick", tk, 64'b1001000);
        check_eq("reen_clk", ck, 64'b1101100);

        // Config while idle: applied on the next edge
        enable = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_int   = 8'd6;
        cfg_frac  = 4'd0;
        step();
        cfg_valid = 1'b0;
        check_eq("idle_ready_lo", 64'(cfg_ready), 64'd0);
        step();
        check_eq("idle_int", 64'(active_int), 64'd6);
        check_eq("idle_ready_hi", 64'(cfg_ready), 64'd1);
        enable = 1'b1;
        collect(6, tk, ck);
        check_eq("d6_tick", tk, 64'b100000);
        check_eq("d6_clk", ck, 64'b111000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
